// File: rtl/gat_pkg.sv
// Shared GAT weight-path definitions: W dimensions, row/index typedefs and the
// row-fetcher FSM state encoding.
package gat_pkg;

  localparam int W_NUM_OF_ROWS = 1433;
  localparam int W_NUM_OF_COLS = 16;
  localparam int W_DATA_WIDTH  = 8;
  localparam int W_ROW_IDX_W   = $clog2(W_NUM_OF_ROWS);

  typedef enum logic [1:0] {
    ST_WAIT_W = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2
  } fetch_state_e;

  typedef logic [W_ROW_IDX_W-1:0]                 w_row_idx_t;
  typedef logic [W_NUM_OF_COLS*W_DATA_WIDTH-1:0]  w_row_t;

endpackage

// File: rtl/w_row_fetcher_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers
// (pointer range 0..2*DEPTH-1, so DEPTH need not be a power of two).
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(2 * DEPTH - 1)) return '0;
    else                         return p + PW'(1);
  endfunction

  function automatic logic [AW-1:0] ptr_idx(input logic [PW-1:0] p);
    if (p >= PW'(DEPTH)) return AW'(p - PW'(DEPTH));
    else                 return AW'(p);
  endfunction

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (ptr_idx(r_wr_ptr) == ptr_idx(r_rd_ptr)) && !o_empty;
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is still legal when the head leaves the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_dout    = r_mem[ptr_idx(r_rd_ptr)];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[ptr_idx(r_wr_ptr)] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/w_row_fetcher.sv
// Reads one W row from the column BRAMs per request and buffers it for the SPMM path.
// Optional macro W_ROW_FETCH_RANGE_CHECK_EN: out-of-range rows return zeros and set err_o.
module w_row_fetcher
  import gat_pkg::*;
#(
  parameter  int DATA_WIDTH      = W_DATA_WIDTH,
  parameter  int NUM_FEATURE_IN  = W_NUM_OF_ROWS,
  parameter  int NUM_FEATURE_OUT = W_NUM_OF_COLS,
  parameter  int BRAM_LAT        = 2,
  parameter  int TAG_WIDTH       = 9,
  localparam int W_ROW_WIDTH     = $clog2(NUM_FEATURE_IN),
  localparam int FIFO_DEPTH      = BRAM_LAT + 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   w_rdy_i,
  input  logic                                   req_vld_i,
  output logic                                   req_rdy_o,
  input  logic [W_ROW_WIDTH-1:0]                 req_row_i,
  input  logic [TAG_WIDTH-1:0]                   req_tag_i,
  output logic [NUM_FEATURE_OUT*W_ROW_WIDTH-1:0] mult_wgt_addrb_flat,
  input  logic [NUM_FEATURE_OUT*DATA_WIDTH-1:0]  mult_wgt_dout_flat,
  output logic                                   rsp_vld_o,
  input  logic                                   rsp_rdy_i,
  output logic [NUM_FEATURE_OUT*DATA_WIDTH-1:0]  rsp_row_o,
  output logic [TAG_WIDTH-1:0]                   rsp_tag_o,
  output logic                                   idle_o
`ifdef W_ROW_FETCH_RANGE_CHECK_EN
  ,
  output logic                                   err_o
`endif
);

  localparam int ROW_BITS = NUM_FEATURE_OUT * DATA_WIDTH;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int FW       = ROW_BITS + TAG_WIDTH;

  fetch_state_e             r_state;
  fetch_state_e             w_state_nxt;
  logic [W_ROW_WIDTH-1:0]   r_addr;
  logic [BRAM_LAT-1:0]      r_pipe_vld;
  logic [TAG_WIDTH-1:0]     r_pipe_tag [BRAM_LAT];
  logic [CNT_W-1:0]         r_inflight;
  logic [CNT_W-1:0]         w_fifo_count;
  logic                     w_fifo_empty;
  logic [FW-1:0]            w_fifo_dout;
  logic [ROW_BITS-1:0]      w_push_row;
  logic                     w_acc;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_credit_ok;
  logic                     w_oor;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_WAIT_W;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_W: begin
        if (w_rdy_i) w_state_nxt = ST_RUN;
        else         w_state_nxt = ST_WAIT_W;
      end
      ST_RUN: begin
        if (!w_rdy_i) w_state_nxt = ST_DRAIN;
        else          w_state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if ((r_inflight == '0) && (w_fifo_count == '0)) w_state_nxt = ST_WAIT_W;
        else                                            w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_WAIT_W;
    endcase
  end

  // Credit: every issued read already owns a FIFO slot, so BRAM reads never stall.
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign req_rdy_o   = (r_state == ST_RUN) && (w_state_nxt == ST_RUN) && w_credit_ok;
  assign w_acc       = req_vld_i && req_rdy_o;
  assign w_push      = r_pipe_vld[BRAM_LAT-1];
  assign rsp_vld_o   = !w_fifo_empty;
  assign w_pop       = rsp_vld_o && rsp_rdy_i;

`ifdef W_ROW_FETCH_RANGE_CHECK_EN
  logic [BRAM_LAT-1:0] r_pipe_oor;
  logic                r_err;

  assign w_oor      = ({1'b0, req_row_i} >= (W_ROW_WIDTH + 1)'(NUM_FEATURE_IN));
  assign w_push_row = r_pipe_oor[BRAM_LAT-1] ? '0 : mult_wgt_dout_flat;
  assign err_o      = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_oor <= '0;
      r_err      <= 1'b0;
    end else begin
      r_pipe_oor[0] <= w_oor;
      for (int i = 1; i < BRAM_LAT; i++) r_pipe_oor[i] <= r_pipe_oor[i-1];
      if (w_acc && w_oor) r_err <= 1'b1;
    end
  end
`else
  assign w_oor      = 1'b0;
  assign w_push_row = mult_wgt_dout_flat;
`endif

  always_ff @(posedge clk) begin
    if (rst)                    r_addr <= '0;
    else if (w_acc && !w_oor)   r_addr <= req_row_i;
  end

  assign mult_wgt_addrb_flat = {NUM_FEATURE_OUT{r_addr}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < BRAM_LAT; i++) r_pipe_tag[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_acc;
      r_pipe_tag[0] <= req_tag_i;
      for (int i = 1; i < BRAM_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_acc, w_push})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({w_push_row, r_pipe_tag[BRAM_LAT-1]}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Stale FIFO storage is masked so an empty buffer always presents zeros.
  assign rsp_row_o = w_fifo_empty ? '0 : w_fifo_dout[FW-1:TAG_WIDTH];
  assign rsp_tag_o = w_fifo_empty ? '0 : w_fifo_dout[TAG_WIDTH-1:0];
  assign idle_o    = (r_inflight == '0) && w_fifo_empty;

endmodule

// File: doc/w_row_fetcher.md
# w_row_fetcher

Reads one full row of the weight matrix W out of the per-column weight BRAMs that the weight loader fills, and delivers it as a packed NUM_FEATURE_OUT-wide vector to the SPMM (H×W) datapath. It is the read-side counterpart of the weight loader. It accepts row-index requests, which are H column indices, over a valid/ready handshake. It drives the shared read address of all column BRAMs, absorbs the fixed BRAM read latency, and buffers results so that downstream back-pressure never stalls a BRAM read.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one weight element
- NUM_FEATURE_IN, 1433, rows of W (W_NUM_OF_ROWS)
- NUM_FEATURE_OUT, 16, columns of W (W_NUM_OF_COLS)
- BRAM_LAT, 2, cycles from a column-BRAM address change to valid dout
- TAG_WIDTH, 9, sideband carried with each request (H value plus a last-of-row flag)
- Derived: W_ROW_WIDTH = $clog2(NUM_FEATURE_IN); FIFO_DEPTH = BRAM_LAT+2

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- w_rdy_i  in  1  weight loader has finished filling all column BRAMs
- req_vld_i  in  1  row request valid
- req_rdy_o  out  1  row request accepted when high with req_vld_i
- req_row_i  in  W_ROW_WIDTH  row index into W
- req_tag_i  in  TAG_WIDTH  sideband data, returned unchanged
- mult_wgt_addrb_flat  out  NUM_FEATURE_OUT*W_ROW_WIDTH  read address, replicated to every column BRAM
- mult_wgt_dout_flat  in  NUM_FEATURE_OUT*DATA_WIDTH  column BRAM read data; column 0 sits in the LSBs
- rsp_vld_o  out  1  weight row valid
- rsp_rdy_i  in  1  downstream accepts the row
- rsp_row_o  out  NUM_FEATURE_OUT*DATA_WIDTH  W[req_row] with the same column packing as the input
- rsp_tag_o  out  TAG_WIDTH  tag of that request
- idle_o  out  1  nothing in flight and FIFO empty
- err_o  out  1  sticky out-of-range flag (present only with the configuration macro)

## Operation
- The FSM has three states: WAIT_W, RUN and DRAIN. Reset puts it in WAIT_W.
- WAIT_W → RUN when w_rdy_i = 1.
- RUN → DRAIN when w_rdy_i falls, which happens when the loader is re-run.
- DRAIN → WAIT_W when the in-flight count and the FIFO count are both 0.
- req_rdy_o = (state == RUN) && (inflight + fifo_count < FIFO_DEPTH). This is credit-based, so a read is never issued without guaranteed space for its result.
- On acceptance:
  - addr_reg <= req_row_i, and the register is driven to all NUM_FEATURE_OUT address lanes.
  - A valid/tag shift pipe of length BRAM_LAT records the issue.
  - addr_reg holds its value while no request is accepted.
- When the pipe's last stage is valid, {mult_wgt_dout_flat, tag} is pushed into a FIFO of depth FIFO_DEPTH.
- The FIFO is first-word-fall-through: rsp_* comes from the FIFO head, rsp_vld_o = !empty, and a pop happens on rsp_vld_o && rsp_rdy_i.
- A push and a pop in the same cycle are both honoured and leave the count unchanged.
- The inflight counter increments on accept and decrements on push. Both in the same cycle leave it unchanged.
- The FIFO wrap-around uses pointers one bit wider than the address, so full and empty are distinguished.
- Data is passed through unmodified; the block performs no arithmetic.
- Asserting rst mid-operation:
  - discards in-flight reads and FIFO contents
  - returns the FSM to WAIT_W
  - issues no response for accepted-but-undelivered requests

## Timing
- Reset values:
  - req_rdy_o = 0, rsp_vld_o = 0, idle_o = 1, err_o = 0
  - rsp_row_o = 0, rsp_tag_o = 0
  - mult_wgt_addrb_flat = 0
- Latency: a request accepted in cycle t with the FIFO empty shows rsp_vld_o = 1 in cycle t+BRAM_LAT+1.
- Throughput: one row per cycle, sustained whenever rsp_rdy_i = 1.
- With rsp_rdy_i held low, exactly FIFO_DEPTH requests are accepted before req_rdy_o drops. Issue resumes the cycle after the first pop.
- A fall of w_rdy_i forces req_rdy_o low in the same cycle through the next-state decode. All outstanding responses are still delivered.

## Configuration
- Macro W_ROW_FETCH_RANGE_CHECK_EN.
- When defined, a request with req_row_i ≥ NUM_FEATURE_IN:
  - is accepted
  - issues no BRAM read
  - returns an all-zero row with its tag, in order
  - sets err_o sticky until rst
- When undefined, err_o is absent, no compare logic is built, and out-of-range rows return whatever the BRAM holds.

## Structure
- Shared package gat_pkg holds the FSM state enum (WAIT_W/RUN/DRAIN), the row-index and weight-row typedefs, and the W dimension constants.
- One sub-module, sync_fifo (parameterised width and depth, FWFT, synchronous active-high reset), is instantiated once for the response buffer.

## Test plan
- Reset, then w_rdy_i = 0 with req_vld_i = 1 → req_rdy_o stays 0 and idle_o = 1. Raise w_rdy_i → req_rdy_o = 1 the next cycle.
- Column BRAMs preloaded with W[r][c] = (r+c)&0xFF. Requests for rows 0, 5, 1432 back-to-back with rsp_rdy_i = 1:
  - rows return in order at accept+3, one per cycle
  - row 5, column 15 = 0x14
- rsp_rdy_i = 0 with 10 requests offered → exactly 4 accepted. Release → 4 rows, then the remainder, with no loss or duplication.
- w_rdy_i dropped with 3 requests in flight → all 3 are delivered, the FSM reaches WAIT_W, and idle_o = 1.
- Reset asserted with 2 rows in the FIFO → rsp_vld_o = 0 the next cycle and none of the old rows appear afterwards.
- With W_ROW_FETCH_RANGE_CHECK_EN, request row 1500 with tag 0x1AB → the response is an all-zero row with tag 0x1AB and err_o = 1 stays high.
